// File: rtl/seg7_rx_decoder.sv
// seg7_rx_decoder: samples a time-multiplexed active-low seven-segment bus,
// decodes each digit pattern back to a nibble, assembles NUM_DIGITS digits
// into a frame and offers it on a registered valid/ready output.
module seg7_rx_decoder #(
  parameter  int NUM_DIGITS = 6,
  localparam int IDX_W      = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [6:0]              leds,
  input  logic [IDX_W-1:0]        dig_idx,
  input  logic                    strobe,
  output logic [4*NUM_DIGITS-1:0] data,
  output logic [NUM_DIGITS-1:0]   data_err,
  output logic                    valid,
  input  logic                    ready,
  output logic                    overflow,
  input  logic                    clr_ovf
);

  localparam logic [IDX_W:0] NUM_DIGITS_W = (IDX_W + 1)'(NUM_DIGITS);

  typedef enum logic {
    ST_EMPTY,
    ST_FULL
  } state_e;

  state_e                  state_q, state_d;
  logic [4*NUM_DIGITS-1:0] stage_nib_q, stage_nib_d;
  logic [NUM_DIGITS-1:0]   stage_err_q, stage_err_d;
  logic [NUM_DIGITS-1:0]   seen_q, seen_d;
  logic [NUM_DIGITS-1:0]   seen_hit;
  logic [4*NUM_DIGITS-1:0] data_q, data_d;
  logic [NUM_DIGITS-1:0]   data_err_q, data_err_d;
  logic                    overflow_q, overflow_d;

  logic [3:0]              dec_nib;
  logic                    dec_err;
  logic                    idx_ok;
  logic                    frame_done;
  logic                    load;
  logic                    ovf_set;

  // Pattern-to-nibble decode (inverse of the hex encoder, 7'bgfedcba).
  always_comb begin
    dec_nib = 4'h0;
    dec_err = 1'b0;
    case (leds)
      7'b1000000: dec_nib = 4'h0;
      7'b1111001: dec_nib = 4'h1;
      7'b0100100: dec_nib = 4'h2;
      7'b0110000: dec_nib = 4'h3;
      7'b0011001: dec_nib = 4'h4;
      7'b0010010: dec_nib = 4'h5;
      7'b0000010: dec_nib = 4'h6;
      7'b1111000: dec_nib = 4'h7;
      7'b0000000: dec_nib = 4'h8;
      7'b0010000: dec_nib = 4'h9;
      7'b0001000: dec_nib = 4'hA;
      7'b0000011: dec_nib = 4'hB;
      7'b1000110: dec_nib = 4'hC;
      7'b0100001: dec_nib = 4'hD;
      7'b0000110: dec_nib = 4'hE;
      7'b0001110: dec_nib = 4'hF;
      default:    dec_err = 1'b1;
    endcase
  end

  // Staging: write the strobed digit, track which digits have arrived,
  // and flag the cycle in which the last missing digit lands.
  always_comb begin
    stage_nib_d = stage_nib_q;
    stage_err_d = stage_err_q;
    seen_hit    = seen_q;
    idx_ok      = strobe && ({1'b0, dig_idx} < NUM_DIGITS_W);
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      if (idx_ok && (dig_idx == i[IDX_W-1:0])) begin
        stage_nib_d[4*i +: 4] = dec_nib;
        stage_err_d[i]        = dec_err;
        seen_hit[i]           = 1'b1;
      end
    end
    frame_done = idx_ok && (&seen_hit);
    seen_d     = frame_done ? '0 : seen_hit;
  end

  // Output FSM: decide whether a completed frame is loaded, dropped or
  // whether the held frame is consumed.
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    ovf_set = 1'b0;
    case (state_q)
      ST_EMPTY: begin
        if (frame_done) begin
          load    = 1'b1;
          state_d = ST_FULL;
        end
      end
      ST_FULL: begin
        if (frame_done) begin
          if (ready) begin
            load = 1'b1;
          end else begin
            ovf_set = 1'b1;
          end
        end else if (ready) begin
          state_d = ST_EMPTY;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
  end

  // Output registers: the frame is taken from the staging values that
  // include this cycle's strobe, so the last digit is not a cycle late.
  always_comb begin
    data_d     = data_q;
    data_err_d = data_err_q;
    if (load) begin
      data_d     = stage_nib_d;
      data_err_d = stage_err_d;
    end
    if (ovf_set) begin
      overflow_d = 1'b1;
    end else if (clr_ovf) begin
      overflow_d = 1'b0;
    end else begin
      overflow_d = overflow_q;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // Staging and output datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stage_nib_q <= '0;
      stage_err_q <= '0;
      seen_q      <= '0;
      data_q      <= '0;
      data_err_q  <= '0;
      overflow_q  <= 1'b0;
    end else begin
      stage_nib_q <= stage_nib_d;
      stage_err_q <= stage_err_d;
      seen_q      <= seen_d;
      data_q      <= data_d;
      data_err_q  <= data_err_d;
      overflow_q  <= overflow_d;
    end
  end

  assign data     = data_q;
  assign data_err = data_err_q;
  assign valid    = (state_q == ST_FULL);
  assign overflow = overflow_q;

endmodule

// File: tb/tb_seg7_rx_decoder.sv
// Directed bench for seg7_rx_decoder with a frame scoreboard and a small
// reference model of staging, output handshake and overflow behaviour.
module tb_seg7_rx_decoder;

  localparam logic [6:0] ENC [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  typedef struct packed {
    logic [23:0] d;
    logic [5:0]  e;
  } frame_t;

  logic        clk;
  logic        reset;
  logic [6:0]  leds;
  logic [2:0]  dig_idx;
  logic        strobe;
  logic [23:0] data;
  logic [5:0]  data_err;
  logic        valid;
  logic        ready;
  logic        overflow;
  logic        clr_ovf;

  int pass_cnt = 0;
  int fail_cnt = 0;
  int total_cnt = 0;

  frame_t     sb[$];
  logic [3:0] m_nib [6];
  logic [5:0] m_err;
  logic [5:0] m_seen;
  logic       m_full;
  logic       m_ovf;

  seg7_rx_decoder #(.NUM_DIGITS(6)) dut (
    .clk      (clk),
    .reset    (reset),
    .leds     (leds),
    .dig_idx  (dig_idx),
    .strobe   (strobe),
    .data     (data),
    .data_err (data_err),
    .valid    (valid),
    .ready    (ready),
    .overflow (overflow),
    .clr_ovf  (clr_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total_cnt++;
    assert (obs === expv) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  function automatic void model_dec(input logic [6:0] p, output logic [3:0] n, output logic e);
    n = 4'h0;
    e = 1'b1;
    for (int k = 0; k < 16; k++) begin
      if (ENC[k] === p) begin
        n = k[3:0];
        e = 1'b0;
      end
    end
  endfunction

  function automatic frame_t model_frame();
    frame_t f;
    for (int k = 0; k < 6; k++) f.d[4*k +: 4] = m_nib[k];
    f.e = m_err;
    return f;
  endfunction

  task automatic model_clear();
    sb.delete();
    m_full = 1'b0;
    m_ovf  = 1'b0;
    m_seen = '0;
    m_err  = '0;
    for (int k = 0; k < 6; k++) m_nib[k] = 4'h0;
  endtask

  // One clock: update the model from the inputs currently driven, advance,
  // then compare DUT outputs against the model/scoreboard.
  task automatic cycle();
    logic [3:0] n;
    logic       e;
    logic       done;
    logic       drop;
    done = 1'b0;
    drop = 1'b0;
    if (strobe && (dig_idx < 3'd6)) begin
      model_dec(leds, n, e);
      m_nib[dig_idx] = n;
      m_err[dig_idx] = e;
      m_seen[dig_idx] = 1'b1;
      if (&m_seen) begin
        done   = 1'b1;
        m_seen = '0;
      end
    end
    if (m_full) begin
      if (done) begin
        if (ready) begin
          void'(sb.pop_front());
          sb.push_back(model_frame());
        end else begin
          drop = 1'b1;
        end
      end else if (ready) begin
        void'(sb.pop_front());
        m_full = 1'b0;
      end
    end else if (done) begin
      sb.push_back(model_frame());
      m_full = 1'b1;
    end
    if (drop) m_ovf = 1'b1;
    else if (clr_ovf) m_ovf = 1'b0;
    @(posedge clk);
    #1;
    chk("valid", valid, m_full);
    chk("overflow", overflow, m_ovf);
    if (m_full) begin
      chk("sb_data", data, sb[0].d);
      chk("sb_err", data_err, sb[0].e);
    end
  endtask

  task automatic send(input int idx, input logic [6:0] pat);
    leds    = pat;
    dig_idx = idx[2:0];
    strobe  = 1'b1;
    cycle();
    strobe  = 1'b0;
    leds    = '1;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cycle();
  endtask

  task automatic accept();
    ready = 1'b1;
    cycle();
    ready = 1'b0;
  endtask

  task automatic async_reset();
    reset = 1'b1;
    #1;
    chk("rst_data", data, 24'h0);
    chk("rst_err", data_err, 6'h0);
    chk("rst_valid", valid, 1'b0);
    chk("rst_ovf", overflow, 1'b0);
    model_clear();
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    reset   = 1'b1;
    leds    = '1;
    dig_idx = '0;
    strobe  = 1'b0;
    ready   = 1'b0;
    clr_ovf = 1'b0;
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    chk("init_data", data, 24'h0);
    chk("init_err", data_err, 6'h0);
    chk("init_valid", valid, 1'b0);
    chk("init_ovf", overflow, 1'b0);
    reset = 1'b0;
    idle(2);

    // Digits 1..6 in order, consumer stalled, then accepted.
    for (int i = 0; i < 6; i++) send(i, ENC[i+1]);
    chk("t2_data", data, 24'h654321);
    chk("t2_err", data_err, 6'h00);
    idle(3);
    accept();

    // Blank pattern on digit 2 decodes as 0 with its error flag set.
    for (int i = 0; i < 6; i++) send(i, (i == 2) ? 7'b1111111 : 7'b0001000);
    chk("t3_data", data, 24'hAAA0AA);
    chk("t3_err", data_err, 6'b000100);
    accept();

    // Second frame completes while the first is still held.
    for (int i = 0; i < 6; i++) send(i, ENC[i+7]);
    for (int i = 0; i < 6; i++) send(i, ENC[i+3]);
    chk("t4_ovf", overflow, 1'b1);
    chk("t4_hold", data, 24'hCBA987);
    idle(1);
    clr_ovf = 1'b1;
    cycle();
    chk("t4_clr", overflow, 1'b0);
    // Drop coinciding with clr_ovf: setting takes priority.
    for (int i = 0; i < 6; i++) send(i, ENC[15-i]);
    chk("t4_set_wins", overflow, 1'b1);
    cycle();
    clr_ovf = 1'b0;
    accept();

    // Consumer accepts in the same cycle the next frame completes.
    for (int i = 0; i < 6; i++) send(i, ENC[i]);
    for (int i = 0; i < 5; i++) send(i, ENC[i+10]);
    ready = 1'b1;
    send(5, ENC[15]);
    ready = 1'b0;
    chk("t5_data", data, 24'hFEDCBA);
    chk("t5_valid", valid, 1'b1);
    chk("t5_ovf", overflow, 1'b0);
    accept();

    // Out-of-range indices ignored; repeated digit overwrites.
    send(0, ENC[7]);
    send(0, ENC[9]);
    for (int i = 1; i < 5; i++) send(i, ENC[i]);
    send(7, ENC[15]);
    send(6, ENC[14]);
    chk("t6_no_complete", valid, 1'b0);
    send(5, ENC[5]);
    chk("t6_nib0", data[3:0], 4'h9);

    // Drop a frame so overflow is set, leave 3 digits staged, then reset.
    for (int i = 0; i < 6; i++) send(i, ENC[i+2]);
    for (int i = 0; i < 3; i++) send(i, ENC[i+8]);
    async_reset();
    for (int i = 3; i < 6; i++) send(i, ENC[i]);
    chk("t1_no_stale", valid, 1'b0);
    for (int i = 0; i < 3; i++) send(i, ENC[i+12]);
    chk("t1_frame", data, 24'h543EDC);
    idle(2);
    accept();
    idle(3);
    chk("t1_one_frame", sb.size(), 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
